// File: rtl/stream_fifo_buffer_pkg.sv
// Shared types and defaults for the receive-side stream buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stream_fifo_buffer_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_BITS = 13;
    localparam int DEF_DROP_W    = 16;

    // Flow-control state towards the producer
    typedef enum logic {
        FC_XON  = 1'b0,
        FC_XOFF = 1'b1
    } fc_state_t;

endpackage

// File: rtl/stream_fifo_buffer_fifo_ram_lvl.sv
// Dual-port RAM with wrapping pointers, a level counter and a registered read port.
// Latency: write visible to a read issued the next cycle; read data registered one cycle after rd_en.
// Backpressure: none internally; writes while full and reads while empty are ignored.
module fifo_ram_lvl
    import stream_fifo_buffer_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clr,
    input  logic                 i_wr_en,
    input  logic [DATA_W-1:0]    i_wr_dat,
    input  logic                 i_rd_en,
    output logic [DATA_W-1:0]    o_rd_dat,
    output logic [ADDR_BITS:0]   o_level,
    output logic                 o_ram_empty,
    output logic                 o_full
);

    localparam int                DEPTH   = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_L = (ADDR_BITS + 1)'(DEPTH);

    logic [DATA_W-1:0]    r_mem [DEPTH];
    logic [ADDR_BITS-1:0] r_wr_ptr;
    logic [ADDR_BITS-1:0] r_rd_ptr;
    logic [ADDR_BITS:0]   r_level;
    logic [DATA_W-1:0]    r_rd_dat;
    logic                 w_wr;
    logic                 w_rd;

    assign o_full      = (r_level == DEPTH_L);
    assign o_ram_empty = (r_level == '0);
    assign w_wr        = i_wr_en & ~o_full & ~i_clr;
    assign w_rd        = i_rd_en & ~o_ram_empty & ~i_clr;

    // Storage array, deliberately not reset
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_dat;
        end
    end

    // Registered read port; this register is the consumer-facing data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_dat <= '0;
        end else if (w_rd) begin
            r_rd_dat <= r_mem[r_rd_ptr];
        end
    end

    // Pointers wrap naturally at the power-of-two depth; clear snaps them home
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + ADDR_BITS'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + ADDR_BITS'(1);
        end
    end

    // Level tracks RAM occupancy; simultaneous push and pop leave it unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
        end else if (i_clr) begin
            r_level <= '0;
        end else begin
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + (ADDR_BITS + 1)'(1);
                2'b01:   r_level <= r_level - (ADDR_BITS + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_rd_dat = r_rd_dat;
    assign o_level  = r_level;

endmodule

// File: rtl/stream_fifo_buffer.sv
// Receive buffer from an unstallable producer to a valid/ready consumer, with XON/XOFF and drop stats.
// Latency: word written in cycle N is presented with out_valid at N+2; one word per cycle sustained.
// Backpressure: consumer stalls hold out_data/out_valid; producer is only asked to stop via xoff, excess words dropped.
module stream_fifo_buffer
    import stream_fifo_buffer_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int XOFF_LVL  = 2 ** ADDR_BITS - 64,
    parameter int XON_LVL   = 2 ** ADDR_BITS / 4,
    parameter int DROP_W    = DEF_DROP_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_valid,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 flush,
    input  logic                 stats_clr,
    output logic [ADDR_BITS:0]   level,
    output logic                 empty,
    output logic                 full,
    output logic                 xoff,
    output logic                 overflow,
    output logic                 overflow_sticky,
    output logic [DROP_W-1:0]    drop_cnt
);

    localparam logic [ADDR_BITS:0] XOFF_L   = (ADDR_BITS + 1)'(XOFF_LVL);
    localparam logic [ADDR_BITS:0] XON_L    = (ADDR_BITS + 1)'(XON_LVL);
    localparam logic [DROP_W-1:0]  DROP_MAX = {DROP_W{1'b1}};

    logic [ADDR_BITS:0] w_level;
    logic               w_full;
    logic               w_ram_empty;
    logic               w_wr_en;
    logic               w_rd_en;
    logic               w_overflow;
    logic               r_out_valid;
    logic               r_overflow_sticky;
    logic [DROP_W-1:0]  r_drop_cnt;
    fc_state_t          r_fc_state;
    fc_state_t          w_fc_next;

    // Full is judged on the registered level: a same-cycle pop never frees a slot for the write
    assign w_wr_en    = in_valid & ~w_full & ~flush;
    assign w_overflow = in_valid &  w_full & ~flush;
    // Refill the output stage whenever it is empty or being emptied this cycle
    assign w_rd_en    = ~w_ram_empty & (~r_out_valid | out_ready) & ~flush;

    fifo_ram_lvl #(
        .DATA_W    (DATA_W),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (flush),
        .i_wr_en     (w_wr_en),
        .i_wr_dat    (in_data),
        .i_rd_en     (w_rd_en),
        .o_rd_dat    (out_data),
        .o_level     (w_level),
        .o_ram_empty (w_ram_empty),
        .o_full      (w_full)
    );

    // Output-stage valid: set by a read, cleared by acceptance or flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_rd_en) begin
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Flow-control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fc_state <= FC_XON;
        end else begin
            r_fc_state <= w_fc_next;
        end
    end

    // Hysteresis between the XOFF and XON thresholds; flush always releases the producer
    always_comb begin
        w_fc_next = r_fc_state;
        if (flush) begin
            w_fc_next = FC_XON;
        end else begin
            case (r_fc_state)
                FC_XON:  if (w_level >= XOFF_L) w_fc_next = FC_XOFF;
                FC_XOFF: if (w_level <= XON_L)  w_fc_next = FC_XON;
                default: w_fc_next = FC_XON;
            endcase
        end
    end

    // Drop statistics; a clear wins over a same-cycle drop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt        <= '0;
            r_overflow_sticky <= 1'b0;
        end else if (stats_clr) begin
            r_drop_cnt        <= '0;
            r_overflow_sticky <= 1'b0;
        end else if (w_overflow) begin
            r_overflow_sticky <= 1'b1;
            if (r_drop_cnt != DROP_MAX) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
        end
    end

    assign out_valid       = r_out_valid;
    assign level           = w_level;
    assign full            = w_full;
    assign empty           = (w_level == '0) & ~r_out_valid;
    assign xoff            = (r_fc_state == FC_XOFF);
    assign overflow        = w_overflow;
    assign overflow_sticky = r_overflow_sticky;
    assign drop_cnt        = r_drop_cnt;

endmodule

// File: tb/tb_stream_fifo_buffer.sv
// Self-checking bench for stream_fifo_buffer at depth 16, XOFF 12, XON 4, 4-bit drop counter.
// Latency: n/a.
// Backpressure: consumer ready driven per scenario.
module tb_stream_fifo_buffer;

    localparam int DW    = 8;
    localparam int AB    = 4;
    localparam int DEPTH = 16;
    localparam int DRW   = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [DW-1:0]  in_data;
    logic           in_valid;
    logic [DW-1:0]  out_data;
    logic           out_valid;
    logic           out_ready;
    logic           flush;
    logic           stats_clr;
    logic [AB:0]    level;
    logic           empty;
    logic           full;
    logic           xoff;
    logic           overflow;
    logic           overflow_sticky;
    logic [DRW-1:0] drop_cnt;

    int checks   = 0;
    int failures = 0;

    // Scoreboard and reference model state
    logic [DW-1:0] q[$];
    int            m_lvl    = 0;
    bit            m_ov     = 1'b0;
    int            pops     = 0;
    int            exp_drop = 0;

    stream_fifo_buffer #(
        .DATA_W    (DW),
        .ADDR_BITS (AB),
        .XOFF_LVL  (12),
        .XON_LVL   (4),
        .DROP_W    (DRW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .flush           (flush),
        .stats_clr       (stats_clr),
        .level           (level),
        .empty           (empty),
        .full            (full),
        .xoff            (xoff),
        .overflow        (overflow),
        .overflow_sticky (overflow_sticky),
        .drop_cnt        (drop_cnt)
    );

    always #5 clk = ~clk;

    // One clock: at the falling edge compare against the model, pop accepted words, push written words
    task automatic tick();
        bit            acc;
        bit            rd;
        logic [DW-1:0] exp_d;
        @(negedge clk);
        if (!rst_n) begin
            m_lvl = 0;
            m_ov  = 1'b0;
            q.delete();
        end else begin
            checks++;
            if (out_valid !== m_ov) begin
                failures++;
                $display("FAIL sb_out_valid got=%b exp=%b t=%0t", out_valid, m_ov, $time);
            end
            checks++;
            if (level !== 5'(m_lvl)) begin
                failures++;
                $display("FAIL sb_level got=%0d exp=%0d t=%0t", level, m_lvl, $time);
            end
            if (m_ov && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_underrun got=word exp=none t=%0t", $time);
                end else begin
                    exp_d = q.pop_front();
                    pops++;
                    if (out_data !== exp_d) begin
                        failures++;
                        $display("FAIL sb_data got=%h exp=%h t=%0t", out_data, exp_d, $time);
                    end
                end
            end
            acc = in_valid && !flush && (m_lvl != DEPTH);
            rd  = (m_lvl != 0) && (!m_ov || out_ready) && !flush;
            if (flush) begin
                m_lvl = 0;
                m_ov  = 1'b0;
                q.delete();
            end else begin
                if (acc) q.push_back(in_data);
                m_lvl = m_lvl + int'(acc) - int'(rd);
                m_ov  = rd ? 1'b1 : (out_ready ? 1'b0 : m_ov);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        stats_clr = 1'b0;
    endtask

    task automatic do_flush();
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
        checks++; if (level !== 5'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", level); end
        checks++; if ({xoff, overflow, overflow_sticky, full} !== 4'b0000) begin failures++; $display("FAIL rst_flags got=%b exp=0000", {xoff, overflow, overflow_sticky, full}); end
        checks++; if (drop_cnt !== 4'd0) begin failures++; $display("FAIL rst_drop got=%0d exp=0", drop_cnt); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", empty); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        idle_inputs();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_n1 got=%b exp=0", out_valid); end
        in_data = 8'h22;
        tick();
        checks++; if ({out_valid, out_data} !== {1'b1, 8'h11}) begin failures++; $display("FAIL lat_n2 got=%b/%h exp=1/11", out_valid, out_data); end
        in_data = 8'h33;
        tick();
        checks++; if (out_data !== 8'h22) begin failures++; $display("FAIL basic_2nd got=%h exp=22", out_data); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_data !== 8'h33) begin failures++; $display("FAIL basic_3rd got=%h exp=33", out_data); end
        tick();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL basic_empty got=%b exp=1", empty); end
    endtask

    task automatic test_stall();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h40 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({out_valid, out_data, level} !== {1'b1, 8'h40, 5'd4}) begin
                failures++;
                $display("FAIL stall_hold got=%b/%h/%0d exp=1/40/4", out_valid, out_data, level);
            end
        end
        out_ready = 1'b1;
        pops = 0;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (pops != 5) begin failures++; $display("FAIL stall_drain_count got=%0d exp=5", pops); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL stall_drain_empty got=%b exp=1", empty); end
    endtask

    task automatic test_overflow();
        bit exp_ov;
        idle_inputs();
        // One word parks in the output register, so 21 writes are needed to drop 4
        for (int i = 0; i < 21; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            #1;
            exp_ov = (m_lvl == DEPTH);
            checks++;
            if (overflow !== exp_ov) begin failures++; $display("FAIL ovf_pulse i=%0d got=%b exp=%b", i, overflow, exp_ov); end
            if (exp_ov) exp_drop = (exp_drop == 15) ? 15 : exp_drop + 1;
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_idle got=%b exp=0", overflow); end
        checks++; if ({full, level} !== {1'b1, 5'd16}) begin failures++; $display("FAIL ovf_full got=%b/%0d exp=1/16", full, level); end
        checks++; if (drop_cnt !== 4'd4) begin failures++; $display("FAIL ovf_drop4 got=%0d exp=4", drop_cnt); end
        checks++; if (overflow_sticky !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow_sticky); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL ovf_head got=%h exp=00", out_data); end
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1;
            exp_drop = (exp_drop == 15) ? 15 : exp_drop + 1;
            tick();
        end
        checks++; if (drop_cnt !== 4'(exp_drop)) begin failures++; $display("FAIL drop_saturate got=%0d exp=%0d", drop_cnt, exp_drop); end
        // Clear wins over a drop in the same cycle
        stats_clr = 1'b1;
        #1;
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL clr_ovf got=%b exp=1", overflow); end
        tick();
        exp_drop  = 0;
        stats_clr = 1'b0;
        checks++; if ({drop_cnt, overflow_sticky} !== 5'd0) begin failures++; $display("FAIL stats_clr got=%0d/%b exp=0/0", drop_cnt, overflow_sticky); end
        // A pop in the same cycle does not make room
        out_ready = 1'b1;
        #1;
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL full_pop_ovf got=%b exp=1", overflow); end
        exp_drop = 1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (drop_cnt !== 4'd1) begin failures++; $display("FAIL full_pop_drop got=%0d exp=1", drop_cnt); end
        do_flush();
    endtask

    task automatic test_xoff();
        idle_inputs();
        for (int i = 0; i < 20 && m_lvl < 12; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h80 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        checks++; if ({level, xoff} !== {5'd12, 1'b0}) begin failures++; $display("FAIL xoff_delay got=%0d/%b exp=12/0", level, xoff); end
        tick();
        checks++; if (xoff !== 1'b1) begin failures++; $display("FAIL xoff_set got=%b exp=1", xoff); end
        out_ready = 1'b1;
        for (int i = 0; i < 20 && m_lvl > 5; i++) tick();
        out_ready = 1'b0;
        tick();
        checks++; if ({level, xoff} !== {5'd5, 1'b1}) begin failures++; $display("FAIL xoff_hyst got=%0d/%b exp=5/1", level, xoff); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if ({level, xoff} !== {5'd4, 1'b1}) begin failures++; $display("FAIL xon_delay got=%0d/%b exp=4/1", level, xoff); end
        tick();
        checks++; if (xoff !== 1'b0) begin failures++; $display("FAIL xon_release got=%b exp=0", xoff); end
        do_flush();
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        out_ready = 1'b1;
        pops      = 0;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i * 7 + 3);
            #1;
            checks++;
            if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_ovf i=%0d got=%b exp=0", i, overflow); end
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        tick();
        checks++; if (pops != 100) begin failures++; $display("FAIL b2b_count got=%0d exp=100", pops); end
        checks++; if (drop_cnt !== 4'(exp_drop)) begin failures++; $display("FAIL b2b_drop got=%0d exp=%0d", drop_cnt, exp_drop); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%b exp=1", empty); end
    endtask

    task automatic test_flush();
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hC0 + 8'(i);
            tick();
        end
        checks++; if ({level, out_valid} !== {5'd9, 1'b1}) begin failures++; $display("FAIL flush_pre got=%0d/%b exp=9/1", level, out_valid); end
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if ({level, out_valid, xoff, empty} !== {5'd0, 1'b0, 1'b0, 1'b1}) begin failures++; $display("FAIL flush_clear got=%0d/%b/%b/%b exp=0/0/0/1", level, out_valid, xoff, empty); end
        checks++; if (drop_cnt !== 4'(exp_drop)) begin failures++; $display("FAIL flush_drop got=%0d exp=%0d", drop_cnt, exp_drop); end
        for (int i = 0; i < 20 && m_lvl < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hD0 + 8'(i);
            tick();
        end
        checks++; if ({full, xoff} !== 2'b11) begin failures++; $display("FAIL flush_full_pre got=%b/%b exp=1/1", full, xoff); end
        // Writes during flush are discarded without counting as drops
        flush = 1'b1;
        #1;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL flush_no_ovf got=%b exp=0", overflow); end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if ({level, xoff, drop_cnt} !== {5'd0, 1'b0, 4'(exp_drop)}) begin failures++; $display("FAIL flush_full_post got=%0d/%b/%0d exp=0/0/%0d", level, xoff, drop_cnt, exp_drop); end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hE0 + 8'(i);
            tick();
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, out_data, level} !== {1'b0, 8'h00, 5'd0}) begin failures++; $display("FAIL arst_data got=%b/%h/%0d exp=0/00/0", out_valid, out_data, level); end
        checks++; if ({xoff, overflow_sticky, drop_cnt, overflow} !== 7'd0) begin failures++; $display("FAIL arst_stats got=%b/%b/%0d/%b exp=0/0/0/0", xoff, overflow_sticky, drop_cnt, overflow); end
        in_valid = 1'b0;
        exp_drop = 0;
        tick();
        rst_n = 1'b1;
        tick();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick();
        in_valid = 1'b0;
        pops = 0;
        tick();
        tick();
        checks++; if (pops != 1) begin failures++; $display("FAIL arst_recover got=%0d exp=1", pops); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_xoff();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
